// File: rtl/byte_logic_arbiter.sv
// Round-robin sharing of one 8-bit byte-logic unit among NREQ requesters.
// Winner operands are latched at grant; the result is captured after ALU_LAT wait cycles.
module byte_logic_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ALU_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op_flat,
    input  logic [8*NREQ-1:0]    a_flat,
    input  logic [8*NREQ-1:0]    b_flat,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [7:0]           result,
    output logic                 busy,
    output logic [1:0]           alu_op,
    output logic [7:0]           alu_in0,
    output logic [7:0]           alu_in1,
    input  logic [7:0]           alu_out
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] in0;
        logic [7:0] in1;
    } alu_req_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [7:0]        result_q, result_d;
    logic              busy_q, busy_d;
    alu_req_t          opnd_q, opnd_d;

    logic [1:0]        op_arr [NREQ];
    logic [7:0]        a_arr  [NREQ];
    logic [7:0]        b_arr  [NREQ];
    logic              arb_hit;
    logic [PTR_W-1:0]  arb_idx;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  ptr_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = op_flat[2*g +: 2];
        assign a_arr[g]  = a_flat[8*g +: 8];
        assign b_arr[g]  = b_flat[8*g +: 8];
    end

    // First requesting index at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = PTR_W'((32'(ptr_q) + off) % NREQ);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign ptr_next = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_hit) state_d = ST_ISSUE;
            ST_ISSUE: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        opnd_d   = opnd_q;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    win_d      = arb_idx;
                    gnt_d      = NREQ'(1) << arb_idx;
                    cnt_d      = CNT_W'(ALU_LAT);
                    opnd_d.op  = op_arr[arb_idx];
                    opnd_d.in0 = a_arr[arb_idx];
                    opnd_d.in1 = b_arr[arb_idx];
                end
            end
            ST_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = alu_out;
                    gnt_d    = '0;
                    done_d   = NREQ'(1) << win_q;
                    ptr_d    = ptr_next;
                    opnd_d   = '0;
                end
            end
            default: begin
                gnt_d  = '0;
                opnd_d = '0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            opnd_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            opnd_q   <= opnd_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign result  = result_q;
    assign busy    = busy_q;
    assign alu_op  = opnd_q.op;
    assign alu_in0 = opnd_q.in0;
    assign alu_in1 = opnd_q.in1;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
    a_gnt_done_excl: assert property (@(posedge clk) disable iff (!rst_n) (gnt_q & done_q) == '0);

endmodule

// File: tb/tb_byte_logic_arbiter.sv
// Directed bench: a zero-latency instance and a two-cycle-latency instance,
// each served by a small combinational byte-logic model.
module tb_byte_logic_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'b00:   return x | y;
            2'b01:   return x & y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // Instance with ALU_LAT = 0
    logic        rst_n0;
    logic [3:0]  req0;
    logic [1:0]  op0 [4];
    logic [7:0]  a0  [4];
    logic [7:0]  b0  [4];
    logic [7:0]  op_flat0;
    logic [31:0] a_flat0, b_flat0;
    logic [3:0]  gnt0, done0;
    logic [7:0]  result0, alu_in00, alu_in10, alu_out0;
    logic [1:0]  alu_op0;
    logic        busy0;

    assign op_flat0 = {op0[3], op0[2], op0[1], op0[0]};
    assign a_flat0  = {a0[3], a0[2], a0[1], a0[0]};
    assign b_flat0  = {b0[3], b0[2], b0[1], b0[0]};
    assign alu_out0 = alu_f(alu_op0, alu_in00, alu_in10);

    byte_logic_arbiter #(.NREQ(4), .ALU_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .req(req0), .op_flat(op_flat0),
        .a_flat(a_flat0), .b_flat(b_flat0), .gnt(gnt0), .done(done0),
        .result(result0), .busy(busy0), .alu_op(alu_op0), .alu_in0(alu_in00),
        .alu_in1(alu_in10), .alu_out(alu_out0)
    );

    // Instance with ALU_LAT = 2
    logic        rst_n2;
    logic [3:0]  req2;
    logic [1:0]  op2 [4];
    logic [7:0]  a2  [4];
    logic [7:0]  b2  [4];
    logic [7:0]  op_flat2;
    logic [31:0] a_flat2, b_flat2;
    logic [3:0]  gnt2, done2;
    logic [7:0]  result2, alu_in02, alu_in12, alu_out2;
    logic [1:0]  alu_op2;
    logic        busy2;

    assign op_flat2 = {op2[3], op2[2], op2[1], op2[0]};
    assign a_flat2  = {a2[3], a2[2], a2[1], a2[0]};
    assign b_flat2  = {b2[3], b2[2], b2[1], b2[0]};
    assign alu_out2 = alu_f(alu_op2, alu_in02, alu_in12);

    byte_logic_arbiter #(.NREQ(4), .ALU_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .req(req2), .op_flat(op_flat2),
        .a_flat(a_flat2), .b_flat(b_flat2), .gnt(gnt2), .done(done2),
        .result(result2), .busy(busy2), .alu_op(alu_op2), .alu_in0(alu_in02),
        .alu_in1(alu_in12), .alu_out(alu_out2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [1:0] i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        op0[i] = op;
        a0[i]  = a;
        b0[i]  = b;
    endtask

    task automatic set2(input logic [1:0] i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        op2[i] = op;
        a2[i]  = a;
        b2[i]  = b;
    endtask

    // One zero-latency operation from an IDLE cycle: grant, done, back to IDLE.
    task automatic run_op0(input logic [3:0] w, input logic [7:0] res);
        tick();
        check("gnt", 32'(gnt0), 32'(w));
        check("busy_issue", 32'(busy0), 32'(1));
        tick();
        check("done", 32'(done0), 32'(w));
        check("gnt_clear", 32'(gnt0), 32'(0));
        check("result", 32'(result0), 32'(res));
        tick();
        check("done_pulse", 32'(done0), 32'(0));
        check("busy_idle", 32'(busy0), 32'(0));
        check("result_hold", 32'(result0), 32'(res));
    endtask

    initial begin
        rst_n0 = 1'b0;
        rst_n2 = 1'b0;
        req0   = 4'b1111;
        req2   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set0(2'(i), 2'b00, 8'(1 << i), 8'h80);
            set2(2'(i), 2'b00, 8'h00, 8'h00);
        end

        // Reset held for two edges with all requests up
        tick();
        tick();
        check("rst_gnt", 32'(gnt0), 32'(0));
        check("rst_done", 32'(done0), 32'(0));
        check("rst_result", 32'(result0), 32'(0));
        check("rst_busy", 32'(busy0), 32'(0));
        check("rst_in0", 32'(alu_in00), 32'(0));
        check("rst_in1", 32'(alu_in10), 32'(0));
        rst_n0 = 1'b1;

        // Round robin with all requests held: 0,1,2,3,0
        run_op0(4'b0001, 8'h81);
        run_op0(4'b0010, 8'h82);
        run_op0(4'b0100, 8'h84);
        run_op0(4'b1000, 8'h88);
        run_op0(4'b0001, 8'h81);

        // Single OR op from requester 0 (pointer at 1 wraps to 0)
        req0 = 4'b0001;
        set0(2'd0, 2'b00, 8'h05, 8'h10);
        tick();
        check("single_gnt", 32'(gnt0), 32'(4'b0001));
        check("single_op", 32'(alu_op0), 32'(2'b00));
        check("single_in0", 32'(alu_in00), 32'(8'h05));
        check("single_in1", 32'(alu_in10), 32'(8'h10));
        tick();
        check("single_done", 32'(done0), 32'(4'b0001));
        check("single_res", 32'(result0), 32'(8'h15));
        tick();
        check("single_idle_in0", 32'(alu_in00), 32'(0));
        // Re-grant three cycles after the first; req dropped mid-ISSUE still completes
        tick();
        check("regrant", 32'(gnt0), 32'(4'b0001));
        req0 = 4'b0000;
        tick();
        check("drop_done", 32'(done0), 32'(4'b0001));
        check("drop_res", 32'(result0), 32'(8'h15));
        tick();

        // AND, XOR, wrap from pointer 3, NOT, then 1001 fairness
        req0 = 4'b0010;
        set0(2'd1, 2'b01, 8'hF0, 8'h3C);
        run_op0(4'b0010, 8'h30);
        req0 = 4'b0100;
        set0(2'd2, 2'b10, 8'hAA, 8'h0F);
        run_op0(4'b0100, 8'hA5);
        req0 = 4'b0101;
        run_op0(4'b0001, 8'h15);
        req0 = 4'b1000;
        set0(2'd3, 2'b11, 8'h3C, 8'hFF);
        run_op0(4'b1000, 8'hC3);
        req0 = 4'b1001;
        run_op0(4'b0001, 8'h15);
        run_op0(4'b1000, 8'hC3);
        req0 = 4'b0000;

        // Latency-2 instance: reset in the second ISSUE cycle drops the op
        req2 = 4'b0010;
        set2(2'd1, 2'b10, 8'h12, 8'h34);
        rst_n2 = 1'b1;
        tick();
        check("l2_gnt1", 32'(gnt2), 32'(4'b0010));
        tick();
        check("l2_gnt1_hold", 32'(gnt2), 32'(4'b0010));
        rst_n2 = 1'b0;
        tick();
        check("midrst_gnt", 32'(gnt2), 32'(0));
        check("midrst_done", 32'(done2), 32'(0));
        check("midrst_res", 32'(result2), 32'(0));
        check("midrst_busy", 32'(busy2), 32'(0));
        rst_n2 = 1'b1;
        tick();
        check("rearb_gnt", 32'(gnt2), 32'(4'b0010));
        tick();
        tick();
        check("rearb_nodone", 32'(done2), 32'(0));
        tick();
        check("rearb_done", 32'(done2), 32'(4'b0010));
        check("rearb_res", 32'(result2), 32'(8'h26));
        req2 = 4'b0000;
        tick();

        // AND FF & 0F: grant for three cycles, done on the fourth edge
        req2 = 4'b0001;
        set2(2'd0, 2'b01, 8'hFF, 8'h0F);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("lat_gnt", 32'(gnt2), 32'(4'b0001));
            check("lat_in0", 32'(alu_in02), 32'(8'hFF));
            check("lat_in1", 32'(alu_in12), 32'(8'h0F));
            check("lat_nodone", 32'(done2), 32'(0));
            check("lat_res_hold", 32'(result2), 32'(8'h26));
        end
        tick();
        check("lat_done", 32'(done2), 32'(4'b0001));
        check("lat_res", 32'(result2), 32'(8'h0F));
        check("lat_gnt_clr", 32'(gnt2), 32'(0));
        req2 = 4'b0000;
        tick();
        check("lat_done_clr", 32'(done2), 32'(0));

        // Pointer is 1 now; after reset both 0 and 1 request and 0 must win
        rst_n2 = 1'b0;
        req2 = 4'b0011;
        tick();
        rst_n2 = 1'b1;
        tick();
        check("ptr_rst_gnt", 32'(gnt2), 32'(4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
